// File: rtl/tx_frame_pkg.sv
// Shared types and constants for the serial frame transmitter.
// Holds the FSM state encoding, CRC-8 constants and the per-bit CRC step.
package tx_frame_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREAMBLE,
      S_SYNC,
      S_DATA,
      S_CRC
   } state_t;

   localparam logic [7:0] CRC8_POLY        = 8'h07;
   localparam logic [7:0] CRC8_INIT        = 8'h00;
   localparam logic [7:0] SYNC_WORD_DEF    = 8'hD5;
   localparam int         PREAMBLE_LEN_DEF = 8;

   // One MSB-first CRC-8 step for a single serial bit.
   function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
      return {crc[6:0], 1'b0} ^ ({8{crc[7] ^ bit_in}} & CRC8_POLY);
   endfunction

endpackage

// File: rtl/frame_serializer_if.sv
// Word-in / bit-out handshake bundle between the word source, serializer and encoder.
// The slave modport is the serializer's view; master is the surrounding system.
interface frame_serializer_if #(
   parameter int DATA_W = 16
);
   logic [DATA_W-1:0] word_in;
   logic              word_valid;
   logic              word_ready;
   logic              bit_out;
   logic              bit_valid;
   logic              bit_ready;

   modport master (
      output word_in, word_valid, bit_ready,
      input  word_ready, bit_out, bit_valid
   );

   modport slave (
      input  word_in, word_valid, bit_ready,
      output word_ready, bit_out, bit_valid
   );
endinterface

// File: rtl/crc8_serial.sv
// Serial CRC-8 accumulator: synchronous clear, per-bit enable.
// crc_nxt exposes the post-update value so the caller can use it in the same cycle.
module crc8_serial
   import tx_frame_pkg::*;
(
   input  logic       clk_sys,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       en,
   input  logic       bit_in,
   output logic [7:0] crc,
   output logic [7:0] crc_nxt
);

   assign crc_nxt = crc8_step(crc, bit_in);

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         crc <= '0;
      end else if (clr) begin
         crc <= CRC8_INIT;
      end else if (en) begin
         crc <= crc_nxt;
      end
   end

endmodule

// File: rtl/frame_serializer.sv
// Frame serializer: preamble, sync word, payload and CRC-8 shifted out MSB-first
// over a valid/ready bit stream toward the Manchester encoder.
//
// state      | meaning
// S_IDLE     | no frame; word_ready follows tx_en
// S_PREAMBLE | alternating 1/0 preamble bits
// S_SYNC     | start-of-frame delimiter, MSB-first
// S_DATA     | latched payload word, MSB-first, feeding the CRC
// S_CRC      | frozen CRC-8, MSB-first
module frame_serializer
   import tx_frame_pkg::*;
#(
   parameter int         DATA_W       = 16,
   parameter int         PREAMBLE_LEN = PREAMBLE_LEN_DEF,
   parameter logic [7:0] SYNC_WORD    = SYNC_WORD_DEF
) (
   input  logic                clk_sys,
   input  logic                rst_n,
   input  logic                tx_en,
   frame_serializer_if.slave   fs,
   output logic                busy,
   output logic                frame_done
);

   localparam int CNT_W = 5;
   localparam int IDX_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PREAMBLE_LEN - 1);
   localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(7);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] word_q;
   logic              bit_out_q, bit_d;
   logic              bit_valid_q;
   logic              done_q, done_d;
   logic              load, crc_clr, crc_en;
   logic              xfer;
   logic [7:0]        crc_q, crc_nxt, crc_src;

   crc8_serial u_crc (
      .clk_sys (clk_sys),
      .rst_n   (rst_n),
      .clr     (crc_clr),
      .en      (crc_en),
      .bit_in  (bit_out_q),
      .crc     (crc_q),
      .crc_nxt (crc_nxt)
   );

   assign xfer          = bit_valid_q && fs.bit_ready;
   assign fs.word_ready = (state_q == S_IDLE) && tx_en;
   assign fs.bit_out    = bit_out_q;
   assign fs.bit_valid  = bit_valid_q;
   assign busy          = (state_q != S_IDLE);
   assign frame_done    = done_q;

   // On the last DATA transfer the register has not yet absorbed that bit.
   assign crc_src = (state_q == S_DATA) ? crc_nxt : crc_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      load    = 1'b0;
      crc_clr = 1'b0;
      crc_en  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (fs.word_valid && tx_en) begin
               state_d = S_PREAMBLE;
               cnt_d   = PRE_LAST;
               load    = 1'b1;
               crc_clr = 1'b1;
            end
         end
         S_PREAMBLE: begin
            if (xfer) begin
               if (cnt_q == '0) begin
                  state_d = S_SYNC;
                  cnt_d   = BYTE_LAST;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end
         S_SYNC: begin
            if (xfer) begin
               if (cnt_q == '0) begin
                  state_d = S_DATA;
                  cnt_d   = DATA_LAST;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end
         S_DATA: begin
            if (xfer) begin
               crc_en = 1'b1;
               if (cnt_q == '0) begin
                  state_d = S_CRC;
                  cnt_d   = BYTE_LAST;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end
         S_CRC: begin
            if (xfer) begin
               if (cnt_q == '0) begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
                  done_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
      if (state_q != S_IDLE && !tx_en) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         done_d  = 1'b0;
         crc_en  = 1'b0;
         crc_clr = 1'b1;
      end
   end

   // Bit for the upcoming cycle, selected from the next state and down-count.
   always_comb begin
      bit_d = 1'b0;
      unique case (state_d)
         S_PREAMBLE: bit_d = cnt_d[0];
         S_SYNC:     bit_d = SYNC_WORD[cnt_d[2:0]];
         S_DATA:     bit_d = word_q[cnt_d[IDX_W-1:0]];
         S_CRC:      bit_d = crc_src[cnt_d[2:0]];
         default:    bit_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         word_q      <= '0;
         bit_out_q   <= 1'b0;
         bit_valid_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_out_q   <= bit_d;
         bit_valid_q <= (state_d != S_IDLE);
         done_q      <= done_d;
         if (load) begin
            word_q <= fs.word_in;
         end
      end
   end

endmodule

// File: tb/tb_frame_serializer.sv
// Directed bench for frame_serializer: nominal frames, stalled transfers,
// back-to-back acceptance, abort via tx_en and reset mid-frame.
module tb_frame_serializer;

   logic clk_sys = 1'b0;
   logic rst_n;
   logic tx_en;
   logic busy;
   logic frame_done;

   frame_serializer_if #(.DATA_W(16)) fs ();

   frame_serializer #(
      .DATA_W       (16),
      .PREAMBLE_LEN (8),
      .SYNC_WORD    (8'hD5)
   ) dut (
      .clk_sys    (clk_sys),
      .rst_n      (rst_n),
      .tx_en      (tx_en),
      .fs         (fs.slave),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk_sys = ~clk_sys;

   int          n_chk = 0;
   int          n_err = 0;
   logic [39:0] bits;
   int          nbits;
   int          cycs;
   int          unst;
   int          done_cnt;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called on a negedge while idle; returns on the negedge where the first bit is up.
   task automatic send_word(input logic [15:0] w, input bit hold);
      tx_en         = 1'b1;
      fs.word_in    = w;
      fs.word_valid = 1'b1;
      #1;
      chk("word_ready_idle", fs.word_ready, 1);
      @(negedge clk_sys);
      if (!hold) fs.word_valid = 1'b0;
      chk("first_bit_valid", fs.bit_valid, 1);
      chk("first_bit_one", fs.bit_out, 1);
      chk("busy_on_start", busy, 1);
   endtask

   // bit_ready is high one cycle in every `period`; collects up to `limit` transferred bits.
   task automatic recv_bits(input int period, input int limit,
                            output logic [39:0] b, output int n, output int c, output int u);
      logic prev_stall;
      logic prev_bit;
      prev_stall = 1'b0;
      prev_bit   = 1'b0;
      b = '0;
      n = 0;
      c = 0;
      u = 0;
      while (n < limit && c < 1000) begin
         fs.bit_ready = ((c % period) == period - 1);
         if (prev_stall && fs.bit_out !== prev_bit) u++;
         prev_stall = fs.bit_valid && !fs.bit_ready;
         prev_bit   = fs.bit_out;
         if (fs.bit_valid && fs.bit_ready) begin
            b = {b[38:0], fs.bit_out};
            n++;
         end
         c++;
         @(negedge clk_sys);
      end
      fs.bit_ready = 1'b1;
      chk("bit_count", n, limit);
   endtask

   task automatic frame_end(input string tag);
      chk({tag, "_done"}, frame_done, 1);
      chk({tag, "_valid_low"}, fs.bit_valid, 0);
      chk({tag, "_busy_low"}, busy, 0);
      @(negedge clk_sys);
      chk({tag, "_done_pulse"}, frame_done, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n         = 1'b0;
      tx_en         = 1'b0;
      fs.word_in    = '0;
      fs.word_valid = 1'b0;
      fs.bit_ready  = 1'b1;
      @(negedge clk_sys);
      @(negedge clk_sys);
      chk("rst_bit_valid", fs.bit_valid, 0);
      chk("rst_bit_out", fs.bit_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", frame_done, 0);
      chk("rst_word_ready", fs.word_ready, 0);
      rst_n = 1'b1;
      @(negedge clk_sys);

      // nominal frame, encoder always ready
      send_word(16'h0001, 0);
      recv_bits(1, 40, bits, nbits, cycs, unst);
      chk("t1_bits", bits, 40'hAA_D5_0001_07);
      chk("t1_cycles", cycs, 40);
      frame_end("t1");

      // encoder ready one cycle in four
      send_word(16'h0100, 0);
      recv_bits(4, 40, bits, nbits, cycs, unst);
      chk("t2_bits", bits, 40'hAA_D5_0100_15);
      chk("t2_stall_stable", unst, 0);
      chk("t2_cycles", cycs, 160);
      frame_end("t2");

      // word_valid held: next frame accepted on the frame_done cycle
      send_word(16'h0000, 1);
      recv_bits(1, 40, bits, nbits, cycs, unst);
      chk("t3a_bits", bits, 40'hAA_D5_0000_00);
      chk("t3_done", frame_done, 1);
      chk("t3_gap_valid", fs.bit_valid, 0);
      chk("t3_gap_ready", fs.word_ready, 1);
      @(negedge clk_sys);
      fs.word_valid = 1'b0;
      chk("t3_restart_valid", fs.bit_valid, 1);
      chk("t3_restart_bit", fs.bit_out, 1);
      chk("t3_done_pulse", frame_done, 0);
      recv_bits(1, 40, bits, nbits, cycs, unst);
      chk("t3b_bits", bits, 40'hAA_D5_0000_00);
      frame_end("t3b");

      // abort after 20 transfers
      send_word(16'h0001, 0);
      recv_bits(1, 20, bits, nbits, cycs, unst);
      chk("t4_partial", bits[19:0], 20'hAAD50);
      tx_en = 1'b0;
      @(negedge clk_sys);
      chk("t4_valid_low", fs.bit_valid, 0);
      chk("t4_busy_low", busy, 0);
      done_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         if (frame_done) done_cnt++;
         @(negedge clk_sys);
      end
      chk("t4_no_done", done_cnt, 0);
      send_word(16'h0001, 0);
      recv_bits(1, 40, bits, nbits, cycs, unst);
      chk("t4_fresh_bits", bits, 40'hAA_D5_0001_07);
      frame_end("t4");

      // reset during DATA, then blocked acceptance with tx_en low
      send_word(16'h8000, 0);
      recv_bits(1, 16, bits, nbits, cycs, unst);
      chk("t5_in_data_bit", fs.bit_out, 1);
      chk("t5_in_data_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_valid", fs.bit_valid, 0);
      chk("t5_rst_bit", fs.bit_out, 0);
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_done", frame_done, 0);
      @(negedge clk_sys);
      rst_n         = 1'b1;
      tx_en         = 1'b0;
      fs.word_in    = 16'h0001;
      fs.word_valid = 1'b1;
      #1;
      chk("t5_blocked_ready", fs.word_ready, 0);
      repeat (3) @(negedge clk_sys);
      chk("t5_blocked_valid", fs.bit_valid, 0);
      chk("t5_blocked_busy", busy, 0);
      fs.word_valid = 1'b0;
      @(negedge clk_sys);
      send_word(16'h0001, 0);
      recv_bits(1, 40, bits, nbits, cycs, unst);
      chk("t5_fresh_bits", bits, 40'hAA_D5_0001_07);
      frame_end("t5");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
